iter_mul_unit: RTL and testbench

//   Multi-cycle radix-2 shift-add multiplier that answers the EX stage's multiply handshake.
//   EX raises start with two operands, and this unit returns a full 2*WIDTH-bit product with a done flag.
//   It sits beside the ALU inside EX, and EX keeps its over signal low until mult_end_o is high.

---
 rtl/iter_mul_unit_if.sv | 24 ++
 rtl/iter_mul_unit.sv | 99 +++++++++
 tb/tb_iter_mul_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/iter_mul_unit_if.sv
// Multiply handshake between the EX stage (master) and the iterative multiplier (slave).
interface iter_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic                 mult_start_i;
  logic                 mult_signed_i;
  logic [WIDTH-1:0]     mult_opd1_i;
  logic [WIDTH-1:0]     mult_opd2_i;
  logic                 mult_ack_i;
  logic                 mult_flush_i;
  logic [2*WIDTH-1:0]   product_o;
  logic                 mult_end_o;
  logic                 mult_busy_o;

  modport master (
    output mult_start_i, mult_signed_i, mult_opd1_i, mult_opd2_i, mult_ack_i, mult_flush_i,
    input  product_o, mult_end_o, mult_busy_o
  );

  modport slave (
    input  mult_start_i, mult_signed_i, mult_opd1_i, mult_opd2_i, mult_ack_i, mult_flush_i,
    output product_o, mult_end_o, mult_busy_o
  );
endinterface

// File: rtl/iter_mul_unit.sv
// Radix-2 shift-add multiplier: WIDTH add/shift iterations plus one sign-fixup cycle,
// result held in DONE until EX acknowledges it.
module iter_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  iter_mul_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // hi keeps its carry in acc[2W]; after the shift it lands in acc[2W-1]
  function automatic logic [2*WIDTH:0] shift_add(input logic [2*WIDTH:0] acc,
                                                 input logic [WIDTH-1:0] mag);
    logic [WIDTH:0] sum;
    sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag} : {(WIDTH+1){1'b0}});
    return {1'b0, sum, acc[WIDTH-1:1]};
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic neg);
    return neg ? -p : p;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_a_d   = mag_a_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.mult_start_i && !bus.mult_flush_i) begin
          mag_a_d = mag_of(bus.mult_opd1_i, bus.mult_signed_i);
          acc_d   = {1'b0, {WIDTH{1'b0}}, mag_of(bus.mult_opd2_i, bus.mult_signed_i)};
          neg_d   = bus.mult_signed_i & (bus.mult_opd1_i[WIDTH-1] ^ bus.mult_opd2_i[WIDTH-1]);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == LAST_CNT) begin
          product_d = apply_sign(acc_q[2*WIDTH-1:0], neg_q);
          state_d   = DONE;
        end else begin
          acc_d = shift_add(acc_q, mag_a_q);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.mult_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything but leaves the last product visible
    if (bus.mult_flush_i) begin
      state_d   = IDLE;
      product_d = product_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_a_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_a_q   <= mag_a_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign bus.product_o   = product_q;
  assign bus.mult_end_o  = (state_q == DONE);
  assign bus.mult_busy_o = (state_q == BUSY);

endmodule

// File: tb/tb_iter_mul_unit.sv
// Directed bench for iter_mul_unit: products, latency, DONE hold, flush and async reset.
module tb_iter_mul_unit;
  localparam int W = 32;
  // Steps from the driving negedge until end is seen: start sampled at E0, end after E0+33
  localparam int LAT_STEPS = W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  iter_mul_unit_if #(.WIDTH(W)) itf ();
  iter_mul_unit #(.WIDTH(W)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(itf.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_end(output int lat, output int busy_gap);
    lat = -1;
    busy_gap = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (itf.mult_end_o) begin
        lat = i;
        break;
      end
      if (!itf.mult_busy_o) busy_gap++;
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp);
    int lat, gap;
    itf.mult_start_i  = 1'b1;
    itf.mult_signed_i = sgn;
    itf.mult_opd1_i   = a;
    itf.mult_opd2_i   = b;
    wait_end(lat, gap);
    chk({tag, "_lat"}, 64'(lat), 64'(LAT_STEPS));
    chk({tag, "_busy_gap"}, 64'(gap), 64'd0);
    chk({tag, "_prod"}, itf.product_o, exp);
    chk({tag, "_busy_in_done"}, 64'(itf.mult_busy_o), 64'd0);
    itf.mult_ack_i   = 1'b1;
    itf.mult_start_i = 1'b0;
    step();
    itf.mult_ack_i = 1'b0;
    chk({tag, "_end_after_ack"}, 64'(itf.mult_end_o), 64'd0);
    chk({tag, "_busy_after_ack"}, 64'(itf.mult_busy_o), 64'd0);
  endtask

  initial begin
    int lat, gap, seen;
    logic [63:0] held;
    itf.mult_start_i  = 1'b0;
    itf.mult_signed_i = 1'b0;
    itf.mult_opd1_i   = '0;
    itf.mult_opd2_i   = '0;
    itf.mult_ack_i    = 1'b0;
    itf.mult_flush_i  = 1'b0;

    // Reset state
    step();
    chk("rst_prod", itf.product_o, 64'd0);
    chk("rst_end", 64'(itf.mult_end_o), 64'd0);
    chk("rst_busy", 64'(itf.mult_busy_o), 64'd0);
    rst_n = 1'b1;
    step();

    // Basic and signed products, corners
    run_op("u7x6", 1'b0, 32'd7, 32'd6, 64'd42);
    run_op("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'h5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("s_m3xm5", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd15);
    run_op("u_fffdx5", 1'b0, 32'hFFFF_FFFD, 32'h5, 64'h4_FFFF_FFF1);
    run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("s_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("s_m1x0", 1'b1, 32'hFFFF_FFFF, 32'h0, 64'd0);
    run_op("u_0x9", 1'b0, 32'h0, 32'h9, 64'd0);

    // Hold in DONE with start high, then back-to-back restart across the ack
    itf.mult_start_i  = 1'b1;
    itf.mult_signed_i = 1'b0;
    itf.mult_opd1_i   = 32'd1000;
    itf.mult_opd2_i   = 32'd1000;
    wait_end(lat, gap);
    chk("hold_lat", 64'(lat), 64'(LAT_STEPS));
    chk("hold_prod", itf.product_o, 64'd1000000);
    held = itf.product_o;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_end", 64'(itf.mult_end_o), 64'd1);
      chk("hold_busy", 64'(itf.mult_busy_o), 64'd0);
      chk("hold_prod_stable", itf.product_o, held);
    end
    itf.mult_ack_i    = 1'b1;
    itf.mult_signed_i = 1'b1;
    itf.mult_opd1_i   = 32'h7FFF_FFFF;
    itf.mult_opd2_i   = 32'hFFFF_FFFF;
    step();
    itf.mult_ack_i = 1'b0;
    chk("b2b_idle_end", 64'(itf.mult_end_o), 64'd0);
    chk("b2b_idle_busy", 64'(itf.mult_busy_o), 64'd0);
    wait_end(lat, gap);
    chk("b2b_lat", 64'(lat), 64'(LAT_STEPS));
    chk("b2b_prod", itf.product_o, 64'hFFFF_FFFF_8000_0001);
    itf.mult_ack_i   = 1'b1;
    itf.mult_start_i = 1'b0;
    step();
    itf.mult_ack_i = 1'b0;
    held = itf.product_o;

    // Flush on the 10th BUSY cycle
    itf.mult_start_i  = 1'b1;
    itf.mult_signed_i = 1'b0;
    itf.mult_opd1_i   = 32'd123;
    itf.mult_opd2_i   = 32'd456;
    for (int i = 0; i < 10; i++) step();
    chk("flush_pre_busy", 64'(itf.mult_busy_o), 64'd1);
    itf.mult_flush_i = 1'b1;
    itf.mult_start_i = 1'b0;
    step();
    itf.mult_flush_i = 1'b0;
    chk("flush_busy", 64'(itf.mult_busy_o), 64'd0);
    chk("flush_end", 64'(itf.mult_end_o), 64'd0);
    chk("flush_prod_kept", itf.product_o, held);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (itf.mult_end_o || itf.mult_busy_o) seen++;
    end
    chk("flush_no_end", 64'(seen), 64'd0);
    run_op("post_flush", 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000);

    // Asynchronous reset mid-BUSY
    itf.mult_start_i  = 1'b1;
    itf.mult_signed_i = 1'b1;
    itf.mult_opd1_i   = 32'hFFFF_FFF9;
    itf.mult_opd2_i   = 32'd3;
    step();
    itf.mult_start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("arst_pre_busy", 64'(itf.mult_busy_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(itf.mult_busy_o), 64'd0);
    chk("arst_end", 64'(itf.mult_end_o), 64'd0);
    chk("arst_prod", itf.product_o, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_idle_busy", 64'(itf.mult_busy_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (itf.mult_end_o) seen++;
    end
    chk("arst_no_end", 64'(seen), 64'd0);
    run_op("post_rst", 1'b1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);

    // Start together with flush in IDLE is not accepted
    itf.mult_start_i = 1'b1;
    itf.mult_flush_i = 1'b1;
    itf.mult_opd1_i  = 32'd2;
    itf.mult_opd2_i  = 32'd2;
    step();
    itf.mult_start_i = 1'b0;
    itf.mult_flush_i = 1'b0;
    chk("flush_start_busy", 64'(itf.mult_busy_o), 64'd0);
    step();
    chk("flush_start_busy2", 64'(itf.mult_busy_o), 64'd0);
    chk("flush_start_end", 64'(itf.mult_end_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
